// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned MAX_DIGITS = 10;
  localparam logic [DIGIT_W-1:0] ADD3_TH = DIGIT_W'(5);

  // All-nines BCD pattern for n digits, zero above digit n-1.
  function automatic logic [DIGIT_W*MAX_DIGITS-1:0] all_nines(input int unsigned n);
    logic [DIGIT_W*MAX_DIGITS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) r[DIGIT_W*i +: DIGIT_W] = DIGIT_W'(9);
    end
    return r;
  endfunction

  // 10^n, wide enough for MAX_DIGITS.
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj_c
);

  assign adj_c = (digit >= ADD3_TH) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bin_to_bcd_param.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock,
// valid/ready handshakes on both sides, optional two's-complement input.
module bin_to_bcd_param
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 20,
  parameter int unsigned DIGITS = 7,
  parameter int unsigned SIGNED = 0
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          in_bin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                      out_sign,
  output logic                      out_ovf,
  output logic [DIGITS-1:0]         out_blank
);

  localparam int unsigned BCD_W = DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] LIMIT  = pow10(DIGITS);
  localparam logic [BCD_W-1:0] NINES = BCD_W'(all_nines(DIGITS));
  // Overflow is impossible when every BIN_W-bit magnitude fits in DIGITS digits.
  localparam bit OVF_EN = ((64'd1 << BIN_W) > LIMIT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  mag_q, mag_d;
  logic [BIN_W-1:0]  sh_q, sh_d;
  logic [BCD_W-1:0]  acc_q, acc_d;
  logic              sign_q, sign_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [BCD_W-1:0]  out_bcd_q, out_bcd_d;
  logic              out_sign_q, out_sign_d;
  logic              out_ovf_q, out_ovf_d;
  logic [DIGITS-1:0] out_blank_q, out_blank_d;

  logic [BCD_W-1:0]  acc_adj;
  logic [BCD_W-1:0]  acc_step;
  logic [BIN_W-1:0]  sh_step;
  logic [BIN_W-1:0]  mag_in;
  logic              neg_in;
  logic              ovf_c;
  logic [BCD_W-1:0]  final_bcd;
  logic [DIGITS-1:0] blank_c;
  logic              zero_run;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (acc_q  [g*DIGIT_W +: DIGIT_W]),
      .adj_c (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Datapath: input magnitude, one shift step, final result and blanking.
  always_comb begin
    neg_in = (SIGNED != 0) && in_bin[BIN_W-1];
    mag_in = neg_in ? (~in_bin + BIN_W'(1)) : in_bin;
    // Rotate rather than shift so the discarded accumulator MSB lands in the spent shift register.
    {acc_step, sh_step} = {acc_adj[BCD_W-2:0], sh_q, acc_adj[BCD_W-1]};
    ovf_c     = OVF_EN && (64'(mag_q) >= LIMIT);
    final_bcd = ovf_c ? NINES : acc_step;
    blank_c   = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (final_bcd[DIGIT_W*i +: DIGIT_W] != '0) zero_run = 1'b0;
      blank_c[i] = zero_run;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    sh_d        = sh_q;
    acc_d       = acc_q;
    sign_d      = sign_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_sign_d  = out_sign_q;
    out_ovf_d   = out_ovf_q;
    out_blank_d = out_blank_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = CONV;
          mag_d      = mag_in;
          sh_d       = mag_in;
          sign_d     = neg_in;
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
        end
      end
      CONV: begin
        acc_d = acc_step;
        sh_d  = sh_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_bcd_d   = final_bcd;
          out_ovf_d   = ovf_c;
          out_sign_d  = sign_q;
          out_blank_d = blank_c;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      sh_q        <= '0;
      acc_q       <= '0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_sign_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_blank_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      sign_q      <= sign_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_sign_q  <= out_sign_d;
      out_ovf_q   <= out_ovf_d;
      out_blank_q <= out_blank_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_sign  = out_sign_q;
  assign out_ovf   = out_ovf_q;
  assign out_blank = out_blank_q;

endmodule
